lpif_ustrm_tx_buffer: RTL and testbench

Upstream feeder for the x8 LPIF slave top: accepts 256-bit flits from the link layer with a valid/ready handshake and buffers them in a small FIFO. It stamps each flit with a CRC-8 and drives the `ustrm_*` bus of the slave top under a `pl_trdy` handshake. Link-state changes on `ustrm_state` are sequenced after all in-flight flits have drained. All activity is gated by the delayed online indication.

---
 rtl/lpif_ustrm_pkg.sv | 34 +++
 rtl/lpif_ustrm_fifo.sv | 61 ++++++
 rtl/lpif_ustrm_tx_buffer.sv | 162 ++++++++++++++++
 tb/tb_lpif_ustrm_tx_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpif_ustrm_pkg.sv
// rtl/lpif_ustrm_pkg.sv - shared types, constants and CRC-8 helper for the upstream tx buffer
// Purpose: FSM state enum, FIFO entry layout and the CRC-8 (poly 0x07) over a 256-bit flit.
// Ports: none (package).
package lpif_ustrm_pkg;

    typedef enum logic [1:0] {
        OFFLINE = 2'd0,
        ACTIVE  = 2'd1,
        DRAIN   = 2'd2
    } tx_state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef struct packed {
        logic [1:0]   protid;
        logic [255:0] data;
        logic [7:0]   crc;
    } tx_entry_t;

    // MSB-first serial CRC: init 0, no reflection, no final XOR.
    function automatic logic [7:0] crc8_256(input logic [255:0] data);
        logic [7:0] crc;
        crc = 8'h00;
        for (int i = 255; i >= 0; i--) begin
            if (crc[7] ^ data[i]) begin
                crc = {crc[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                crc = {crc[6:0], 1'b0};
            end
        end
        return crc;
    endfunction

endpackage

// File: rtl/lpif_ustrm_fifo.sv
// rtl/lpif_ustrm_fifo.sv - synchronous FIFO with flush and combinational head
// Purpose: DEPTH-entry storage for flits waiting for the output slot.
// Ports: i_clk/i_rst clock and sync reset; i_flush empties the FIFO; i_push/i_wdata write;
//        i_pop advances the head; o_head current head entry; o_level occupancy;
//        o_empty/o_full status.
module lpif_ustrm_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 266
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_flush,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_wdata,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_head,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_empty,
    output logic                    o_full
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [AW:0]      w_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_level   = r_wptr - r_rptr;
    assign o_level   = w_level;
    assign o_empty   = (w_level == '0);
    assign o_full    = (w_level == LVL_FULL);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/lpif_ustrm_tx_buffer.sv
// rtl/lpif_ustrm_tx_buffer.sv - upstream flit feeder with FIFO, CRC stamp and state sequencing
// Purpose: buffers link-layer flits, stamps CRC-8, drives the ustrm_* bus under pl_trdy and
//          applies ll_state changes only after in-flight flits have drained.
// Ports: clk_wr/rst_wr clock and sync active-high reset; tx_online gates all activity;
//        ll_* link-layer flit input with ll_valid/ll_ready handshake; pl_trdy slave ready;
//        ustrm_* output flit bus; fifo_level occupancy; flit_count transferred flits.
module lpif_ustrm_tx_buffer
    import lpif_ustrm_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int CRC_EN = 1
) (
    input  logic                    clk_wr,
    input  logic                    rst_wr,
    input  logic                    tx_online,
    input  logic [3:0]              ll_state,
    input  logic [1:0]              ll_protid,
    input  logic [255:0]            ll_data,
    input  logic                    ll_valid,
    output logic                    ll_ready,
    input  logic                    pl_trdy,
    output logic [3:0]              ustrm_state,
    output logic [1:0]              ustrm_protid,
    output logic [255:0]            ustrm_data,
    output logic                    ustrm_dvalid,
    output logic [7:0]              ustrm_crc,
    output logic                    ustrm_crc_valid,
    output logic                    ustrm_valid,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [31:0]             flit_count
);

    localparam logic CRC_ON = (CRC_EN != 0);

    tx_state_e        r_state;
    tx_state_e        w_state_nxt;
    logic             r_slot_valid;
    tx_entry_t        r_slot;
    logic [3:0]       r_ustrm_state;
    logic [31:0]      r_flit_count;

    tx_entry_t        w_push_entry;
    tx_entry_t        w_head;
    logic [$clog2(DEPTH):0] w_fifo_level;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic             w_ll_ready;
    logic             w_state_load;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;
    logic             w_xfer;
    logic             w_slot_free;
    logic             w_running;

    assign w_xfer      = r_slot_valid & pl_trdy;
    assign w_slot_free = ~r_slot_valid | w_xfer;
    // Pops only while online in ACTIVE/DRAIN; going offline drops everything.
    assign w_running   = (r_state != OFFLINE) & tx_online;
    assign w_flush     = ~w_running;
    assign w_pop       = w_running & w_slot_free & ~w_fifo_empty;
    assign w_push      = ll_valid & w_ll_ready;

    assign w_push_entry.protid = ll_protid;
    assign w_push_entry.data   = ll_data;
    assign w_push_entry.crc    = CRC_ON ? crc8_256(ll_data) : 8'h00;

    lpif_ustrm_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(tx_entry_t))
    ) u_fifo (
        .i_clk   (clk_wr),
        .i_rst   (rst_wr),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_level (w_fifo_level),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_ll_ready   = 1'b0;
        w_state_load = 1'b0;
        case (r_state)
            OFFLINE: begin
                if (tx_online) begin
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                w_ll_ready = ~w_fifo_full;
                if (ll_state != r_ustrm_state) begin
                    // Nothing in flight: apply the new state immediately.
                    if (w_fifo_empty && !r_slot_valid) begin
                        w_state_load = 1'b1;
                    end else begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_fifo_empty && w_slot_free) begin
                    w_state_load = 1'b1;
                    w_state_nxt  = ACTIVE;
                end
            end
            default: begin
                w_state_nxt = OFFLINE;
            end
        endcase
        if (!tx_online) begin
            w_state_nxt  = OFFLINE;
            w_state_load = 1'b0;
        end
    end

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            r_state       <= OFFLINE;
            r_slot_valid  <= 1'b0;
            r_slot        <= '0;
            r_ustrm_state <= 4'h0;
            r_flit_count  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_flit_count <= r_flit_count + 32'd1;
            end
            if (!w_running) begin
                r_slot_valid <= 1'b0;
                r_slot       <= '0;
            end else if (w_pop) begin
                r_slot_valid <= 1'b1;
                r_slot       <= w_head;
            end else if (w_xfer) begin
                r_slot_valid <= 1'b0;
                r_slot       <= '0;
            end
            if (!tx_online) begin
                r_ustrm_state <= 4'h0;
            end else if (w_state_load) begin
                r_ustrm_state <= ll_state;
            end
        end
    end

    assign ll_ready        = w_ll_ready;
    assign ustrm_state     = r_ustrm_state;
    assign ustrm_protid    = r_slot.protid;
    assign ustrm_data      = r_slot.data;
    assign ustrm_crc       = r_slot.crc;
    assign ustrm_valid     = r_slot_valid;
    assign ustrm_dvalid    = r_slot_valid;
    assign ustrm_crc_valid = CRC_ON & r_slot_valid;
    assign fifo_level      = w_fifo_level;
    assign flit_count      = r_flit_count;

endmodule

// File: tb/tb_lpif_ustrm_tx_buffer.sv
// tb/tb_lpif_ustrm_tx_buffer.sv - self-checking bench for lpif_ustrm_tx_buffer
module tb_lpif_ustrm_tx_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [1:0]   p;
        logic [255:0] d;
        logic [7:0]   c;
    } exp_t;

    logic         clk_wr;
    logic         rst_wr;
    logic         tx_online;
    logic [3:0]   ll_state;
    logic [1:0]   ll_protid;
    logic [255:0] ll_data;
    logic         ll_valid;
    logic         ll_ready;
    logic         pl_trdy;
    logic [3:0]   ustrm_state;
    logic [1:0]   ustrm_protid;
    logic [255:0] ustrm_data;
    logic         ustrm_dvalid;
    logic [7:0]   ustrm_crc;
    logic         ustrm_crc_valid;
    logic         ustrm_valid;
    logic [2:0]   fifo_level;
    logic [31:0]  flit_count;

    logic         n_ll_ready;
    logic [3:0]   n_ustrm_state;
    logic [1:0]   n_ustrm_protid;
    logic [255:0] n_ustrm_data;
    logic         n_ustrm_dvalid;
    logic [7:0]   n_ustrm_crc;
    logic         n_ustrm_crc_valid;
    logic         n_ustrm_valid;
    logic [2:0]   n_fifo_level;
    logic [31:0]  n_flit_count;

    int           n_cmp = 0;
    int           n_err = 0;
    exp_t         sb[$];
    logic [31:0]  exp_count = 0;

    logic         p_rst = 1'b1;
    logic         p_online, p_valid, p_trdy;
    logic [3:0]   p_state;
    logic [1:0]   p_protid;
    logic [255:0] p_data;
    logic [7:0]   p_crc;

    bit           stall_done;
    bit           rnd_done;
    int           stall_w;
    int           rnd_w;
    int           w;

    lpif_ustrm_tx_buffer #(.DEPTH(DEPTH), .CRC_EN(1)) dut (
        .clk_wr(clk_wr), .rst_wr(rst_wr), .tx_online(tx_online), .ll_state(ll_state),
        .ll_protid(ll_protid), .ll_data(ll_data), .ll_valid(ll_valid), .ll_ready(ll_ready),
        .pl_trdy(pl_trdy), .ustrm_state(ustrm_state), .ustrm_protid(ustrm_protid),
        .ustrm_data(ustrm_data), .ustrm_dvalid(ustrm_dvalid), .ustrm_crc(ustrm_crc),
        .ustrm_crc_valid(ustrm_crc_valid), .ustrm_valid(ustrm_valid),
        .fifo_level(fifo_level), .flit_count(flit_count)
    );

    lpif_ustrm_tx_buffer #(.DEPTH(DEPTH), .CRC_EN(0)) dut_nc (
        .clk_wr(clk_wr), .rst_wr(rst_wr), .tx_online(tx_online), .ll_state(ll_state),
        .ll_protid(ll_protid), .ll_data(ll_data), .ll_valid(ll_valid), .ll_ready(n_ll_ready),
        .pl_trdy(pl_trdy), .ustrm_state(n_ustrm_state), .ustrm_protid(n_ustrm_protid),
        .ustrm_data(n_ustrm_data), .ustrm_dvalid(n_ustrm_dvalid), .ustrm_crc(n_ustrm_crc),
        .ustrm_crc_valid(n_ustrm_crc_valid), .ustrm_valid(n_ustrm_valid),
        .fifo_level(n_fifo_level), .flit_count(n_flit_count)
    );

    initial clk_wr = 1'b0;
    always #5 clk_wr = ~clk_wr;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [265:0] obs, input logic [265:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference CRC as the remainder of data(x)*x^8 divided by x^8+x^2+x+1.
    function automatic logic [7:0] ref_crc(input logic [255:0] d);
        logic [263:0] r;
        r = {d, 8'h00};
        for (int i = 263; i >= 8; i--) begin
            if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
        end
        return r[7:0];
    endfunction

    function automatic logic [255:0] rand_data();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Transaction-level model: every accepted flit must come out once, in order, unchanged.
    always @(negedge clk_wr) begin
        exp_t e;
        check_val("flit_count", flit_count, exp_count);
        check_val("valid_flags", {ustrm_dvalid, ustrm_crc_valid}, {ustrm_valid, ustrm_valid});
        if (n_ustrm_valid) begin
            check_val("nocrc_fields", {n_ustrm_crc, n_ustrm_crc_valid}, 0);
            check_val("nocrc_data", n_ustrm_data, ustrm_data);
        end
        if (!ustrm_valid) check_val("idle_zero", {ustrm_protid, ustrm_data, ustrm_crc}, 0);
        if (!p_rst && p_online && p_valid && !p_trdy) begin
            check_val("hold", {ustrm_valid, ustrm_state, ustrm_protid, ustrm_data, ustrm_crc},
                      {1'b1, p_state, p_protid, p_data, p_crc});
        end
        p_rst = rst_wr; p_online = tx_online; p_valid = ustrm_valid; p_trdy = pl_trdy;
        p_state = ustrm_state; p_protid = ustrm_protid; p_data = ustrm_data; p_crc = ustrm_crc;
        if (rst_wr) begin
            sb.delete();
            exp_count = 0;
        end else begin
            if (ustrm_valid && pl_trdy) begin
                exp_count = exp_count + 1;
                if (sb.size() == 0) begin
                    check_val("unexpected_flit", ustrm_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check_val("out_flit", {ustrm_protid, ustrm_data, ustrm_crc}, e);
                end
            end
            if (!tx_online) sb.delete();
            else if (ll_valid && ll_ready) sb.push_back({ll_protid, ll_data, ref_crc(ll_data)});
        end
    end

    task automatic send_flit(input logic [1:0] p, input logic [255:0] d, output int waits);
        bit acc;
        acc = 1'b0;
        waits = 0;
        ll_valid = 1'b1; ll_protid = p; ll_data = d;
        while (!acc && waits < 200) begin
            @(negedge clk_wr);
            acc = ll_ready;
            @(posedge clk_wr); #1;
            if (!acc) waits++;
        end
        if (!acc) check_val("push_timeout", ll_ready, 1);
        ll_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while ((sb.size() != 0 || ustrm_valid) && k < 300) begin
            @(posedge clk_wr); #2;
            k++;
        end
        check_val({tag, "_valid"}, ustrm_valid, 0);
        check_val({tag, "_left"}, sb.size(), 0);
        check_val({tag, "_level"}, fifo_level, 0);
    endtask

    task automatic run_random(input int n, input int pct);
        logic [255:0] d;
        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < n; k++) begin
                    if ($urandom_range(0, 9) == 0) ll_state = 4'($urandom_range(0, 15));
                    d = ($urandom_range(0, 7) == 0) ? 256'h0 : rand_data();
                    send_flit(2'($urandom_range(0, 3)), d, rnd_w);
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk_wr); #1; end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    pl_trdy = ($urandom_range(0, 99) < pct);
                    @(posedge clk_wr); #1;
                end
            end
        join
        pl_trdy = 1'b1;
        wait_drain("rnd");
    endtask

    initial begin
        int xf;
        bit fin;
        bit found;
        rst_wr = 1'b1; tx_online = 1'b0; ll_state = 4'h0; ll_protid = 2'h0;
        ll_data = '0; ll_valid = 1'b0; pl_trdy = 1'b0;
        repeat (3) @(posedge clk_wr);
        #1;
        check_val("rst_valid", {ustrm_valid, ustrm_dvalid, ustrm_crc_valid}, 0);
        check_val("rst_ready", ll_ready, 0);
        check_val("rst_level", fifo_level, 0);
        check_val("rst_count", flit_count, 0);
        check_val("rst_state", ustrm_state, 0);
        check_val("rst_bus", {ustrm_protid, ustrm_data, ustrm_crc}, 0);

        // First flit latency: accepted at end of cycle N, visible in N+2.
        rst_wr = 1'b0; tx_online = 1'b1; pl_trdy = 1'b1;
        send_flit(2'd2, 256'h1, w);
        @(negedge clk_wr);
        check_val("lat_n1_valid", ustrm_valid, 0);
        @(posedge clk_wr); @(negedge clk_wr);
        check_val("lat_n2_valid", ustrm_valid, 1);
        check_val("lat_crc", ustrm_crc, 8'h07);
        check_val("lat_protid", ustrm_protid, 2);
        check_val("lat_data", ustrm_data, 1);
        @(posedge clk_wr); @(negedge clk_wr);
        check_val("lat_count", flit_count, 1);
        @(posedge clk_wr); #1;

        // Back-to-back: 16 flits, ready never drops, 16 consecutive valid cycles.
        fork
            begin
                for (int k = 0; k < 16; k++) begin
                    send_flit(2'($urandom_range(0, 3)), rand_data(), w);
                    check_val("b2b_ready_wait", w, 0);
                end
            end
            begin
                found = 1'b0;
                for (int k = 0; k < 10 && !found; k++) begin
                    @(negedge clk_wr);
                    found = ustrm_valid;
                end
                check_val("b2b_start", ustrm_valid, 1);
                for (int k = 1; k < 16; k++) begin
                    @(negedge clk_wr);
                    check_val("b2b_valid_run", ustrm_valid, 1);
                end
                @(negedge clk_wr);
                check_val("b2b_valid_end", ustrm_valid, 0);
            end
        join
        wait_drain("b2b");

        // Stall: pl_trdy low for 10 cycles while offering 6 flits.
        pl_trdy = 1'b0;
        stall_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) send_flit(2'($urandom_range(0, 3)), rand_data(), stall_w);
                stall_done = 1'b1;
            end
        join_none
        repeat (10) @(negedge clk_wr);
        check_val("stall_level", fifo_level, DEPTH);
        check_val("stall_ready", ll_ready, 0);
        @(posedge clk_wr); #1;
        pl_trdy = 1'b1;
        for (int k = 0; k < 300 && !stall_done; k++) begin @(posedge clk_wr); #1; end
        check_val("stall_done", stall_done, 1);
        wait_drain("stall");

        // State change sequenced behind 3 buffered flits.
        ll_state = 4'h1;
        repeat (2) begin @(posedge clk_wr); #1; end
        check_val("idle_state_apply", ustrm_state, 1);
        pl_trdy = 1'b0;
        for (int k = 0; k < 3; k++) send_flit(2'($urandom_range(0, 3)), rand_data(), w);
        ll_state = 4'h3;
        @(posedge clk_wr); #1;
        pl_trdy = 1'b1;
        xf = 0; fin = 1'b0;
        for (int k = 0; k < 20 && !fin; k++) begin
            @(negedge clk_wr);
            check_val("drain_state", ustrm_state, (xf >= 3) ? 3 : 1);
            check_val("drain_ready", ll_ready, (xf >= 3) ? 1 : 0);
            if (xf >= 3) fin = 1'b1;
            else if (ustrm_valid && pl_trdy) xf++;
        end
        check_val("drain_xfers", xf, 3);
        @(posedge clk_wr); #1;

        // Offline with 3 flits in the FIFO.
        pl_trdy = 1'b0;
        for (int k = 0; k < 4; k++) send_flit(2'($urandom_range(0, 3)), rand_data(), w);
        check_val("pre_off_level", fifo_level, 3);
        tx_online = 1'b0;
        @(posedge clk_wr); #1;
        check_val("off_level", fifo_level, 0);
        check_val("off_valid", ustrm_valid, 0);
        check_val("off_ready", ll_ready, 0);
        check_val("off_state", ustrm_state, 0);
        check_val("off_count", flit_count, exp_count);
        tx_online = 1'b1; ll_state = 4'h0; pl_trdy = 1'b1;
        @(posedge clk_wr); #1;
        run_random(40, 100);
        run_random(60, 60);
        run_random(60, 25);

        // Reset in the middle of traffic with garbage on the inputs.
        pl_trdy = 1'b0;
        for (int k = 0; k < 3; k++) send_flit(2'($urandom_range(0, 3)), rand_data(), w);
        rst_wr = 1'b1; ll_valid = 1'b1; ll_data = rand_data(); ll_state = 4'h5; pl_trdy = 1'b1;
        @(posedge clk_wr); #1;
        rst_wr = 1'b0; ll_valid = 1'b0;
        check_val("mrst_valid", {ustrm_valid, ustrm_dvalid, ustrm_crc_valid}, 0);
        check_val("mrst_ready", ll_ready, 0);
        check_val("mrst_level", fifo_level, 0);
        check_val("mrst_count", flit_count, 0);
        check_val("mrst_state", ustrm_state, 0);
        check_val("mrst_bus", {ustrm_protid, ustrm_data, ustrm_crc}, 0);
        repeat (3) @(posedge clk_wr);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
